// File: rtl/led_uart_reporter_if.sv
// rtl/led_uart_reporter_if.sv - result value in, UART line and busy flag out
interface led_uart_reporter_if;
    logic [31:0] val;
    logic        txd;
    logic        busy;

    // Processor / observer side: supplies the value, watches the line.
    modport master (output val, input txd, input busy);
    // Reporter side: consumes the value, drives the line.
    modport slave (input val, output txd, output busy);
endinterface

// File: rtl/led_uart_reporter.sv
// rtl/led_uart_reporter.sv - reports each new led value as 8 hex chars + CR LF on UART 8N1
module led_uart_reporter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    led_uart_reporter_if.slave   bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [31:0] val_q;
    logic [31:0] last_sent;
    logic [31:0] msg;
    logic [CW-1:0] baud;
    logic [2:0]  bit_idx;
    logic [3:0]  char_idx;
    logic        txd_r;
    logic        busy_r;

    logic [3:0]  nib;
    logic [7:0]  cur_char;
    logic [2:0]  nxt_bit;
    logic        baud_end;

    assign bus.txd  = txd_r;
    assign bus.busy = busy_r;

    assign baud_end = (baud == BAUD_LAST);
    assign nxt_bit  = bit_idx + 3'd1;

    // Character currently being sent: eight nibbles MSB first, then CR, LF.
    always_comb begin
        nib = 4'h0;
        case (char_idx[2:0])
            3'd0: nib = msg[31:28];
            3'd1: nib = msg[27:24];
            3'd2: nib = msg[23:20];
            3'd3: nib = msg[19:16];
            3'd4: nib = msg[15:12];
            3'd5: nib = msg[11:8];
            3'd6: nib = msg[7:4];
            default: nib = msg[3:0];
        endcase
        if (char_idx == 4'd8) begin
            cur_char = 8'h0D;
        end else if (char_idx == 4'd9) begin
            cur_char = 8'h0A;
        end else if (nib < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nib};
        end else begin
            cur_char = 8'h37 + {4'h0, nib};
        end
    end

    // Input sampling plus the transmit FSM; txd and busy are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            val_q     <= 32'h0;
            last_sent <= 32'h0;
            msg       <= 32'h0;
            baud      <= '0;
            bit_idx   <= 3'd0;
            char_idx  <= 4'd0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            val_q <= bus.val;
            case (state)
                IDLE: begin
                    // Only the newest value is compared, so values that came and
                    // went during the previous message are never reported.
                    if (val_q != last_sent) begin
                        msg       <= val_q;
                        last_sent <= val_q;
                        char_idx  <= 4'd0;
                        baud      <= '0;
                        txd_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        txd_r   <= cur_char[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            txd_r <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= nxt_bit;
                            txd_r   <= cur_char[nxt_bit];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (char_idx == 4'd9) begin
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            char_idx <= char_idx + 4'd1;
                            txd_r    <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    txd_r  <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_uart_reporter.sv
// tb/tb_led_uart_reporter.sv - self-checking bench for led_uart_reporter
module tb_led_uart_reporter;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    led_uart_reporter_if bus_if ();

    led_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         busy_runs[$];
    int         frame_err = 0;

    // UART receiver: every one of the 40 samples of a frame must sit inside its bit slot.
    int         rx_s = 0;
    logic       rx_active = 1'b0;
    logic [7:0] rx_byte = 8'h0;
    logic       rx_bit = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (bus_if.txd === 1'b0) begin
                rx_active = 1'b1;
                rx_s = 0;
            end
        end else begin
            rx_s++;
            if (rx_s < CPB) begin
                if (bus_if.txd !== 1'b0) frame_err++;
            end else if (rx_s < 9 * CPB) begin
                if (rx_s % CPB == 0) begin
                    rx_bit = bus_if.txd;
                    rx_byte[rx_s / CPB - 1] = rx_bit;
                end else if (bus_if.txd !== rx_bit) begin
                    frame_err++;
                end
            end else begin
                if (bus_if.txd !== 1'b1) frame_err++;
                if (rx_s == 10 * CPB - 1) begin
                    rx_q.push_back(rx_byte);
                    rx_active = 1'b0;
                end
            end
        end
    end

    // Length of each busy pulse in cycles.
    int busy_run = 0;
    always @(negedge clk) begin
        if (bus_if.busy === 1'b1) begin
            busy_run++;
        end else if (busy_run > 0) begin
            busy_runs.push_back(busy_run);
            busy_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the text a report of v must produce.
    task automatic push_msg(input logic [31:0] v);
        string hexd;
        logic [3:0] n;
        hexd = "0123456789ABCDEF";
        for (int i = 7; i >= 0; i--) begin
            n = v[i*4 +: 4];
            exp_q.push_back(hexd[n]);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic compare_rx(input string tag);
        logic [31:0] obs;
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, i), obs, {24'h0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_runs(input string tag, input int n);
        check({tag, "_nruns"}, 32'(busy_runs.size()), 32'(n));
        foreach (busy_runs[i]) check($sformatf("%s_run%0d", tag, i), 32'(busy_runs[i]), 32'(100 * CPB));
        busy_runs.delete();
    endtask

    // Negedges from a value change until the start bit is seen (bounded).
    task automatic measure_latency(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus_if.txd !== 1'b0 && lat < 20);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus_if.busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'h0, bus_if.busy}, 32'h0);
    endtask

    task automatic send_one(input string tag, input logic [31:0] v);
        int lat;
        bus_if.val = v;
        push_msg(v);
        measure_latency(lat);
        check({tag, "_latency"}, 32'(lat), 32'd2);
        wait_done(tag);
        @(negedge clk);
        compare_rx(tag);
        check_runs(tag, 1);
    endtask

    initial begin
        int          lat;
        int          bad;
        logic [31:0] last;
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] b;

        bus_if.val = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_txd", {31'h0, bus_if.txd}, 32'h1);
        check("reset_busy", {31'h0, bus_if.busy}, 32'h0);
        rst = 1'b0;

        // Quiet after reset: value 0 is never reported.
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus_if.txd !== 1'b1 || bus_if.busy !== 1'b0) bad++;
        end
        check("quiet_bad_cycles", 32'(bad), 32'd0);
        check("quiet_rx", 32'(rx_q.size()), 32'd0);
        busy_runs.delete();

        send_one("single", 32'h1234ABCD);
        last = 32'h1234ABCD;

        // Random values, each differing from the last report.
        for (int k = 0; k < 3; k++) begin
            v = $urandom;
            if (v == last || v == 32'h0) v = last ^ 32'h8000_0001;
            send_one($sformatf("rand%0d", k), v);
            last = v;
        end

        // Coalescing: only the final value set during a message is reported.
        v = (last == 32'h1) ? 32'h2 : 32'h1;
        a = $urandom;
        b = v ^ ($urandom | 32'h1);
        bus_if.val = v;
        push_msg(v);
        push_msg(b);
        measure_latency(lat);
        check("coal_latency", 32'(lat), 32'd2);
        repeat (100) @(negedge clk);
        bus_if.val = a;
        repeat (100) @(negedge clk);
        bus_if.val = b;
        wait_done("coal_first");
        check("coal_gap_txd", {31'h0, bus_if.txd}, 32'h1);
        @(negedge clk);
        check("coal_gap_busy", {31'h0, bus_if.busy}, 32'h1);
        check("coal_gap_start", {31'h0, bus_if.txd}, 32'h0);
        wait_done("coal_second");
        repeat (50) @(negedge clk);
        compare_rx("coal");
        check_runs("coal", 2);
        last = b;

        // Revert suppression: a value that returns to the last report is silent.
        v = (last == 32'hFF) ? 32'hFE : 32'hFF;
        bus_if.val = v;
        push_msg(v);
        measure_latency(lat);
        check("revert_latency", 32'(lat), 32'd2);
        repeat (100) @(negedge clk);
        bus_if.val = 32'h10;
        repeat (100) @(negedge clk);
        bus_if.val = v;
        wait_done("revert");
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus_if.busy !== 1'b0) bad++;
        end
        check("revert_busy_cycles", 32'(bad), 32'd0);
        compare_rx("revert");
        check_runs("revert", 1);

        // Reset mid-message: partial character abandoned, full message after release.
        bus_if.val = 32'hDEADBEEF;
        measure_latency(lat);
        check("rstmid_latency", 32'(lat), 32'd2);
        repeat (150) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_txd", {31'h0, bus_if.txd}, 32'h1);
        check("rstmid_busy", {31'h0, bus_if.busy}, 32'h0);
        rx_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy_runs.delete();
        push_msg(32'hDEADBEEF);
        measure_latency(lat);
        check("rstrel_latency", 32'(lat), 32'd2);
        wait_done("rstrel");
        @(negedge clk);
        compare_rx("rstrel");
        check_runs("rstrel", 1);

        check("frame_errors", 32'(frame_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_uart_reporter.md
# led_uart_reporter

Downstream consumer of the processor's 32-bit `led` result register. Watches the value and, whenever it differs from the last value reported, serialises it as eight uppercase hex ASCII characters plus CR LF over a UART 8N1 transmit line. Lets a bench or board observe every settled program result without a logic analyser. Intermediate values that appear while a message is in flight are coalesced: only the newest is reported.

## Interface

Parameters:
- CLKS_PER_BIT, default 868, clock cycles per UART bit; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- val  input  32  value to report; connected to the processor's `led` output.
- txd  output  1  UART serial data; idle high, 8N1, LSB first.
- busy  output  1  high while a message is being transmitted.

## Operation

- Input register `val_q` samples `val` every cycle. Register `last_sent` holds the last reported value.
- Reset: `txd`=1, `busy`=0, `last_sent`=0, `val_q`=0, state IDLE, all counters 0. A value of 0 after reset is therefore never reported.
- The FSM has four states.
  - IDLE: if `val_q != last_sent`, latch `msg`=`val_q` and `last_sent`=`val_q`, set char index=0, and go to START. Otherwise stay.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `txd`=char[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7. After bit 7, go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. If char index==9, go to IDLE; else increment the char index and go to START.
- Character sequence, index 0..9: nibbles `msg[31:28]` down to `msg[3:0]`, then 0x0D, then 0x0A.
- Nibble to ASCII: n<10 gives 0x30+n; otherwise 0x41+(n-10).
- `msg` is frozen for the whole message. Changes to `val` during a message only update `val_q`.
- Coalescing: on return to IDLE, `val_q` is compared against `last_sent`. A value that changed and then reverted to `last_sent` within one message produces no new message.
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary. Bit index is 3 bits and char index is 4 bits. No counter overflows outside its stated range.

## Timing

- `txd` and `busy` are registered outputs.
- Given `val` changes before edge t:
  - `val_q` updates at edge t.
  - FSM leaves IDLE at edge t+1; `txd` falls and `busy` rises, both visible after edge t+1.
- One character occupies 10×CLKS_PER_BIT cycles. One message occupies exactly 100×CLKS_PER_BIT cycles, and `busy` is high for exactly that count.
- `busy` falls on the same edge that the last stop bit ends (entry to IDLE).
- Minimum gap between messages is 1 IDLE cycle with `txd`=1, then the next start bit.
- Reset asserted mid-message: the next edge gives `txd`=1 and `busy`=0, and the partial character is abandoned.
  - After release, a nonzero `val` produces a complete new message beginning with a start bit.
  - The earliest falling edge of `txd` is the second edge after `rst` is deasserted.
- No flow control input. The block never stalls the processor and never back-pressures.

## Test plan

Use CLKS_PER_BIT=4 in all scenarios; one message = 400 cycles.

- **Quiet after reset:** reset, then hold `val`=0 for 1000 cycles -> `txd` constantly 1, `busy` constantly 0.
- **Single message:** reset, then set `val`=0x1234ABCD -> bench UART decoder receives 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A. `busy` is high for exactly 400 cycles. The start bit falls 2 edges after `val` changes.
- **Bit timing:** during the scenario above, every start, data and stop bit lasts exactly 4 cycles. The stop bit is 1 and the start bit is 0.
- **Coalescing:** send 0x00000001; during its transmission set `val`=0x5, then 0x6 -> after 400 cycles there is one idle cycle, then exactly one message "00000006\r\n". There is no message for 0x5.
- **Revert suppression:** after 0xFF has been reported, set `val`=0x10 and then back to 0xFF, all during an idle-to-busy-free window inside a message for 0xFF -> no further message; `busy` stays 0 afterwards.
- **Reset mid-message:** assert `rst` at cycle 150 of a message for 0xDEADBEEF while `val` stays at 0xDEADBEEF, and hold reset for 3 cycles -> `txd`=1 and `busy`=0 on the next edge. After release, a full "DEADBEEF\r\n" message is decoded with no corrupted partial character.
